// File: rtl/alu_op_sequencer.sv
// Initiator sequencer for the 16-bit combinational ALU: accepts a function request,
// drives the ALU from registers for one or two passes, returns result and flags.
// Build option ALU_SEQ_SATURATE_EN: clamp ADD/SUB/ABSDIFF-pass-1 results on signed overflow.
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_func,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic             alu_Cin,
  output logic [2:0]       alu_Op,
  output logic             alu_invA,
  output logic             alu_invB,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_Out,
  input  logic             alu_Ofl,
  input  logic             alu_Z,
  input  logic             alu_N,
  input  logic             alu_cout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_z,
  output logic             resp_n,
  output logic             resp_ofl,
  output logic             resp_cout,
  output logic             resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_RESP} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic       inv_a;
    logic       inv_b;
    logic       cin;
    logic       sign;
  } ctl_t;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_SEQ  = 4'd10;
  localparam logic [3:0] F_SLT  = 4'd11;
  localparam logic [3:0] F_SLE  = 4'd12;
  localparam logic [3:0] F_SCO  = 4'd13;
  localparam logic [3:0] F_ABSD = 4'd14;
  localparam logic [3:0] F_ILL  = 4'd15;

  // ALU control word for a function; second selects the B-A pass of ABSDIFF.
  function automatic ctl_t f_ctl(input logic [3:0] func, input logic second);
    ctl_t c;
    c      = '0;
    c.sign = 1'b1;
    case (func)
      4'd0:  c.op = 3'b100;
      4'd1:  begin c.op = 3'b100; c.inv_a = 1'b1; c.cin = 1'b1; end
      4'd2:  c.op = 3'b101;
      4'd3:  c.op = 3'b110;
      4'd4:  c.op = 3'b111;
      4'd5:  begin c.op = 3'b111; c.inv_b = 1'b1; end
      4'd6:  c.op = 3'b000;
      4'd7:  c.op = 3'b001;
      4'd8:  c.op = 3'b010;
      4'd9:  c.op = 3'b011;
      4'd10, 4'd11, 4'd12: begin c.op = 3'b100; c.inv_b = 1'b1; c.cin = 1'b1; end
      4'd13: c.op = 3'b100;
      4'd14: begin
        c.op  = 3'b100;
        c.cin = 1'b1;
        if (second) c.inv_a = 1'b1;
        else        c.inv_b = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_func;
  ctl_t             r_ctl;
  ctl_t             w_ctl_next;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] w_alu_a_next;
  logic [WIDTH-1:0] w_alu_b_next;
  logic             w_load;
  logic             w_cap;
  logic [WIDTH-1:0] w_res;
  logic             w_sat_ok;
  logic [WIDTH-1:0] r_res;
  logic             r_z;
  logic             r_n;
  logic             r_ofl;
  logic             r_cout;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Control words default to zero so the ALU sees idle inputs outside the passes.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    w_load       = 1'b0;
    w_cap        = 1'b0;
    w_ctl_next   = '0;
    w_alu_a_next = '0;
    w_alu_b_next = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_load       = 1'b1;
          w_state_next = S_PASS1;
          w_ctl_next   = f_ctl(req_func, 1'b0);
          if (req_func != F_ILL) begin
            w_alu_a_next = req_a;
            w_alu_b_next = req_b;
          end
        end
      end
      S_PASS1: begin
        if (r_func == F_ABSD && alu_N) begin
          w_state_next = S_PASS2;
          w_ctl_next   = f_ctl(r_func, 1'b1);
          w_alu_a_next = r_alu_a;
          w_alu_b_next = r_alu_b;
        end else begin
          w_cap        = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_PASS2: begin
        w_cap        = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sat_ok = (r_func == F_ADD) || (r_func == F_SUB) ||
               (r_func == F_ABSD && r_state == S_PASS1);
    case (r_func)
      F_SEQ:   w_res = {{(WIDTH-1){1'b0}}, alu_Z};
      F_SLT:   w_res = {{(WIDTH-1){1'b0}}, alu_N};
      F_SLE:   w_res = {{(WIDTH-1){1'b0}}, alu_N | alu_Z};
      F_SCO:   w_res = {{(WIDTH-1){1'b0}}, alu_cout};
      F_ILL:   w_res = '0;
      default: w_res = alu_Out;
    endcase
`ifdef ALU_SEQ_SATURATE_EN
    if (w_sat_ok && alu_Ofl)
      w_res = alu_N ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_func  <= '0;
      r_ctl   <= '0;
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_res   <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_ofl   <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ctl   <= w_ctl_next;
      r_alu_a <= w_alu_a_next;
      r_alu_b <= w_alu_b_next;
      if (w_load) r_func <= req_func;
      if (w_cap) begin
        // The illegal code never ran an ALU pass, so its flags are forced low.
        r_res  <= w_res;
        r_z    <= (r_func != F_ILL) & alu_Z;
        r_n    <= (r_func != F_ILL) & alu_N;
        r_ofl  <= (r_func != F_ILL) & alu_Ofl;
        r_cout <= (r_func != F_ILL) & alu_cout;
        r_err  <= (r_func == F_ILL);
      end
    end
  end

  assign alu_A       = r_alu_a;
  assign alu_B       = r_alu_b;
  assign alu_Op      = r_ctl.op;
  assign alu_invA    = r_ctl.inv_a;
  assign alu_invB    = r_ctl.inv_b;
  assign alu_Cin     = r_ctl.cin;
  assign alu_sign    = r_ctl.sign;
  assign resp_result = r_res;
  assign resp_z      = r_z;
  assign resp_n      = r_n;
  assign resp_ofl    = r_ofl;
  assign resp_cout   = r_cout;
  assign resp_err    = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU closes the loop, and an arithmetic
// reference model predicts result, flags and latency for directed and random requests.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_func;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [15:0] alu_A;
  logic [15:0] alu_B;
  logic        alu_Cin;
  logic [2:0]  alu_Op;
  logic        alu_invA;
  logic        alu_invB;
  logic        alu_sign;
  logic [15:0] alu_Out;
  logic        alu_Ofl;
  logic        alu_Z;
  logic        alu_N;
  logic        alu_cout;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_result;
  logic        resp_z;
  logic        resp_n;
  logic        resp_ofl;
  logic        resp_cout;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_a(req_a), .req_b(req_b),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin), .alu_Op(alu_Op),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
    .alu_Out(alu_Out), .alu_Ofl(alu_Ofl), .alu_Z(alu_Z), .alu_N(alu_N), .alu_cout(alu_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_z(resp_z), .resp_n(resp_n), .resp_ofl(resp_ofl), .resp_cout(resp_cout),
    .resp_err(resp_err)
  );

  // Combinational ALU: operand inversion, shifts by B[3:0], adder with sign-corrected N.
  logic [15:0] m_a, m_b, m_out;
  logic [16:0] m_sum;
  always_comb begin
    m_a      = alu_invA ? ~alu_A : alu_A;
    m_b      = alu_invB ? ~alu_B : alu_B;
    m_sum    = {1'b0, m_a} + {1'b0, m_b} + {16'b0, alu_Cin};
    m_out    = '0;
    alu_Ofl  = 1'b0;
    alu_cout = 1'b0;
    case (alu_Op)
      3'b000: m_out = (m_a << m_b[3:0]) | (m_a >> (5'd16 - {1'b0, m_b[3:0]}));
      3'b001: m_out = m_a << m_b[3:0];
      3'b010: m_out = (m_a >> m_b[3:0]) | (m_a << (5'd16 - {1'b0, m_b[3:0]}));
      3'b011: m_out = m_a >> m_b[3:0];
      3'b100: begin
        m_out    = m_sum[15:0];
        alu_cout = m_sum[16];
        alu_Ofl  = (m_a[15] == m_b[15]) && (m_sum[15] != m_a[15]);
      end
      3'b101: m_out = m_a | m_b;
      3'b110: m_out = m_a ^ m_b;
      default: m_out = m_a & m_b;
    endcase
    alu_Out = m_out;
    alu_Z   = (m_out == 16'h0000);
    alu_N   = (alu_Op == 3'b100) ? (m_out[15] ^ alu_Ofl) : m_out[15];
  end

  typedef struct packed {
    logic [15:0] res;
    logic z, n, o, c, e;
    logic [1:0] lat;
  } exp_t;

  // Signed/unsigned integer arithmetic result: d is the exact signed value, carry the unsigned carry.
  function automatic exp_t arith(input int d, input logic carry, input logic sat_ok);
    exp_t e;
    e     = '0;
    e.lat = 2'd2;
    e.res = d[15:0];
    e.o   = (d > 32767) || (d < -32768);
    e.n   = (d < 0);
    e.c   = carry;
    e.z   = (e.res == 16'h0000);
`ifdef ALU_SEQ_SATURATE_EN
    if (sat_ok && e.o) e.res = e.n ? 16'h8000 : 16'h7FFF;
`else
    if (sat_ok && 1'b0) e.res = 16'h0000;
`endif
    return e;
  endfunction

  function automatic exp_t logic_res(input int r);
    exp_t e;
    e     = '0;
    e.lat = 2'd2;
    e.res = r[15:0];
    e.z   = (e.res == 16'h0000);
    e.n   = e.res[15];
    return e;
  endfunction

  function automatic exp_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int sa, sb, ua, ub, s;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    s  = b[3:0];
    case (f)
      4'd0:  e = arith(sa + sb, (ua + ub) > 65535, 1'b1);
      4'd1:  e = arith(sb - sa, ub >= ua, 1'b1);
      4'd2:  e = logic_res(ua | ub);
      4'd3:  e = logic_res(ua ^ ub);
      4'd4:  e = logic_res(ua & ub);
      4'd5:  e = logic_res(ua & ~ub);
      4'd6:  e = logic_res((ua << s) | (ua >> (16 - s)));
      4'd7:  e = logic_res(ua << s);
      4'd8:  e = logic_res((ua >> s) | (ua << (16 - s)));
      4'd9:  e = logic_res(ua >> s);
      4'd10: begin e = arith(sa - sb, ua >= ub, 1'b0); e.res = {15'b0, e.z}; end
      4'd11: begin e = arith(sa - sb, ua >= ub, 1'b0); e.res = {15'b0, e.n}; end
      4'd12: begin e = arith(sa - sb, ua >= ub, 1'b0); e.res = {15'b0, e.n | e.z}; end
      4'd13: begin e = arith(sa + sb, (ua + ub) > 65535, 1'b0); e.res = {15'b0, e.c}; end
      4'd14: begin
        if (sa - sb >= 0) e = arith(sa - sb, ua >= ub, 1'b1);
        else begin
          e     = arith(sb - sa, ub >= ua, 1'b0);
          e.lat = 2'd3;
        end
      end
      default: begin e = '0; e.e = 1'b1; e.lat = 2'd2; end
    endcase
    return e;
  endfunction

  // Expected {Op, invA, invB, Cin, sign} while the first pass is on the ALU.
  function automatic logic [6:0] exp_ctl(input logic [3:0] f);
    case (f)
      4'd0:  return 7'b100_0_0_0_1;
      4'd1:  return 7'b100_1_0_1_1;
      4'd2:  return 7'b101_0_0_0_1;
      4'd3:  return 7'b110_0_0_0_1;
      4'd4:  return 7'b111_0_0_0_1;
      4'd5:  return 7'b111_0_1_0_1;
      4'd6:  return 7'b000_0_0_0_1;
      4'd7:  return 7'b001_0_0_0_1;
      4'd8:  return 7'b010_0_0_0_1;
      4'd9:  return 7'b011_0_0_0_1;
      4'd13: return 7'b100_0_0_0_1;
      4'd15: return 7'b000_0_0_0_0;
      default: return 7'b100_0_1_1_1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_txn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b, input int hold);
    exp_t e;
    int   cyc;
    logic [20:0] want;
    e    = model(f, a, b);
    want = {e.res, e.z, e.n, e.o, e.c, e.e};
    @(negedge clk);
    req_valid = 1'b1;
    req_func  = f;
    req_a     = a;
    req_b     = b;
    chk("req_ready_idle", 40'(req_ready), 40'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("pass1_ctl", 40'({alu_Op, alu_invA, alu_invB, alu_Cin, alu_sign}), 40'(exp_ctl(f)));
    chk("pass1_operands", 40'({alu_A, alu_B}), (f == 4'd15) ? 40'd0 : 40'({a, b}));
    cyc = 1;
    while (!resp_valid && cyc < 10) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("latency", 40'(cyc), 40'(e.lat));
    chk("resp", 40'({resp_result, resp_z, resp_n, resp_ofl, resp_cout, resp_err}), 40'(want));
    chk("resp_quiet_alu", 40'({req_ready, alu_A, alu_Op, alu_invA, alu_invB, alu_Cin, alu_sign}), 40'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 chk("hold", 40'({resp_valid, req_ready, resp_result, resp_z, resp_n, resp_ofl, resp_cout, resp_err}),
             40'({2'b10, want}));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("handshake", 40'({resp_valid, req_ready}), 40'(2'b01));
    $display("txn func=%0d a=%h b=%h -> result=%h z=%0b n=%0b ofl=%0b cout=%0b err=%0b lat=%0d",
             f, a, b, resp_result, resp_z, resp_n, resp_ofl, resp_cout, resp_err, cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  f;
    logic [15:0] a, b;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_func   = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_handshake", 40'({req_ready, resp_valid}), 40'(2'b10));
    chk("reset_resp", 40'({resp_result, resp_z, resp_n, resp_ofl, resp_cout, resp_err}), 40'd0);
    chk("reset_alu", 40'({alu_A, alu_B, alu_Op, alu_invA, alu_invB, alu_Cin, alu_sign}), 40'd0);
    rst = 1'b0;

    do_txn(4'd0,  16'h7FFF, 16'h0001, 0);
    do_txn(4'd11, 16'h8000, 16'h0001, 0);
    do_txn(4'd10, 16'h1234, 16'h1234, 0);
    do_txn(4'd14, 16'h0003, 16'h000A, 0);
    do_txn(4'd14, 16'h000A, 16'h0003, 0);
    do_txn(4'd7,  16'h0001, 16'hFFF4, 5);
    do_txn(4'd15, 16'hABCD, 16'h1234, 1);
    do_txn(4'd1,  16'h8000, 16'h7FFF, 0);

    // Reset while an ABSDIFF is in its second pass.
    @(negedge clk);
    req_valid = 1'b1;
    req_func  = 4'd14;
    req_a     = 16'h0003;
    req_b     = 16'h000A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("absdiff_pass2_ctl", 40'({alu_Op, alu_invA, alu_invB, alu_Cin, alu_sign}), 40'(7'b100_1_0_1_1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_handshake", 40'({req_ready, resp_valid}), 40'(2'b10));
    chk("midreset_alu", 40'({alu_A, alu_B, alu_Op, alu_invA, alu_invB, alu_Cin, alu_sign}), 40'd0);
    chk("midreset_resp", 40'({resp_result, resp_z, resp_n, resp_ofl, resp_cout, resp_err}), 40'd0);
    rst = 1'b0;
    do_txn(4'd14, 16'h0003, 16'h000A, 0);

    for (int n = 0; n < 150; n++) begin
      f = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      do_txn(f, a, b, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
